// File: rtl/up_program_loader.sv
// Frame-based program-memory loader: parses SYNC/addr/len/data/csum byte frames
// and writes each payload byte into uP program memory, holding the uP in reset meanwhile.
module up_program_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         ADDR_W    = 12,
  parameter int         DATA_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              up_hold,
  output logic              done,
  output logic              error,
  output logic              busy
);

  // Header bytes carry the address/length bits above bit 7 in their low HI_W bits.
  localparam int HI_W = ADDR_W - 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA, S_CSUM
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic [7:0]          csum_q, csum_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                mem_we_q, mem_we_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                in_ready_q, in_ready_d;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    csum_d     = csum_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    in_ready_d = 1'b1;

    if (in_valid) begin
      case (state_q)
        S_IDLE: begin
          if (in_data == SYNC_BYTE) state_d = S_ADDR_H;
        end
        S_ADDR_H: begin
          if (in_data[7:HI_W] != '0) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ptr_d[ADDR_W-1:8] = in_data[HI_W-1:0];
            state_d           = S_ADDR_L;
          end
        end
        S_ADDR_L: begin
          ptr_d[7:0] = in_data;
          state_d    = S_LEN_H;
        end
        S_LEN_H: begin
          if (in_data[7:HI_W] != '0) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            rem_d[ADDR_W-1:8] = in_data[HI_W-1:0];
            state_d           = S_LEN_L;
          end
        end
        S_LEN_L: begin
          rem_d[7:0] = in_data;
          csum_d     = 8'h00;
          state_d    = S_DATA;
        end
        S_DATA: begin
          mem_we_d   = 1'b1;
          mem_addr_d = ptr_q;
          mem_data_d = in_data;
          ptr_d      = ptr_q + 1'b1;
          csum_d     = csum_q + in_data;
          if (rem_q == '0) state_d = S_CSUM;
          else             rem_d   = rem_q - 1'b1;
        end
        S_CSUM: begin
          if (in_data == csum_q) done_d  = 1'b1;
          else                   error_d = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      csum_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      csum_q     <= csum_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      done_q     <= done_d;
      error_q    <= error_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Frame activity is exactly "not idle", so up_hold drops with the done/error pulse.
  assign busy     = (state_q != S_IDLE);
  assign up_hold  = busy;
  assign in_ready = in_ready_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_we   = mem_we_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_up_program_loader.sv
// Self-checking bench for up_program_loader: frames built from byte lists, expected
// writes/checksums computed from frame fields with plain arithmetic.
module tb_up_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we, up_hold, done, error, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, nrdy_cnt = 0;

  up_program_loader dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .up_hold(up_hold), .done(done), .error(error), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    if (mem_we === 1'b1) wr_cnt++;
    if (done === 1'b1) done_cnt++;
    if (error === 1'b1) err_cnt++;
    if (done === 1'b1 && error === 1'b1) both_cnt++;
    if (!reset && in_ready !== 1'b1) nrdy_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One accepted byte: present at a falling edge, consumed on the next rising edge.
  task automatic put(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic gap(input int lo, input int hi);
    int g;
    g = (hi > lo) ? lo + int'($urandom_range(hi - lo, 0)) : lo;
    repeat (g) @(negedge clock);
  endtask

  // csum_sel < 0 sends the correct checksum, otherwise the given byte.
  task automatic run_frame(input logic [11:0] addr, input logic [7:0] data[$],
                           input int csum_sel, input int lo, input int hi, input string tag);
    logic [7:0]  sum;
    logic [7:0]  cbyte;
    logic [11:0] nn;
    logic [11:0] ea;
    bit          good;
    int          w0, d0, e0;
    sum = 8'h00;
    foreach (data[i]) sum = sum + data[i];
    cbyte = (csum_sel < 0) ? sum : 8'(csum_sel);
    good  = (cbyte == sum);
    nn    = 12'(data.size() - 1);
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;

    put(8'hA5);
    n_cmp++;
    if ({up_hold, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL %s hold_rise: up_hold/busy=%b%b want 11", tag, up_hold, busy);
    end
    gap(lo, hi); put({4'h0, addr[11:8]});
    gap(lo, hi); put(addr[7:0]);
    gap(lo, hi); put({4'h0, nn[11:8]});
    gap(lo, hi); put(nn[7:0]);
    for (int i = 0; i < data.size(); i++) begin
      gap(lo, hi);
      put(data[i]);
      ea = addr + 12'(i);
      n_cmp++;
      if ({mem_we, mem_addr, mem_data, up_hold} !== {1'b1, ea, data[i], 1'b1}) begin
        n_bad++;
        $display("FAIL %s write[%0d]: we=%b addr=%h data=%h hold=%b want we=1 addr=%h data=%h hold=1",
                 tag, i, mem_we, mem_addr, mem_data, up_hold, ea, data[i]);
      end
    end
    gap(lo, hi);
    put(cbyte);
    n_cmp++;
    if ({done, error, up_hold, busy, mem_we} !== {good, !good, 3'b000}) begin
      n_bad++;
      $display("FAIL %s end: done=%b error=%b hold=%b busy=%b we=%b want done=%b error=%b hold=0 busy=0 we=0",
               tag, done, error, up_hold, busy, mem_we, good, !good);
    end
    @(negedge clock);
    n_cmp++;
    if ({done, error} !== 2'b00) begin
      n_bad++;
      $display("FAIL %s pulse_width: done=%b error=%b want 00", tag, done, error);
    end
    n_cmp++;
    if ((wr_cnt - w0) != data.size() || (done_cnt - d0) != int'(good) || (err_cnt - e0) != int'(!good)) begin
      n_bad++;
      $display("FAIL %s counts: writes=%0d done=%0d err=%0d want writes=%0d done=%0d err=%0d",
               tag, wr_cnt - w0, done_cnt - d0, err_cnt - e0, data.size(), int'(good), int'(!good));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({in_ready, mem_addr, mem_data, mem_we, up_hold, done, error, busy} !==
        {1'b1, 12'h000, 8'h00, 5'b00000}) begin
      n_bad++;
      $display("FAIL reset_values: rdy=%b addr=%h data=%h we=%b hold=%b done=%b err=%b busy=%b want rdy=1 rest 0",
               in_ready, mem_addr, mem_data, mem_we, up_hold, done, error, busy);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_directed();
    logic [7:0] q[$];
    q = '{8'h0F, 8'h16, 8'hE0};
    run_frame(12'h000, q, -1, 0, 0, "frame_good");
    run_frame(12'h000, q, 8'h0C, 0, 0, "frame_badcsum");
    q = '{8'h3C, 8'h4D};
    run_frame(12'hFFF, q, 8'h89, 0, 0, "frame_wrap");
  endtask

  task automatic test_bad_header(input bit at_len);
    logic [7:0] b;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    b = {4'(1 + $urandom_range(14, 0)), 4'($urandom)};
    put(8'hA5);
    if (at_len) begin
      put(8'h00); put(8'h00);
    end
    put(b);
    n_cmp++;
    if ({error, done, up_hold, busy, mem_we} !== 5'b10000) begin
      n_bad++;
      $display("FAIL bad_header(len=%0d,%h): err=%b done=%b hold=%b busy=%b we=%b want 10000",
               at_len, b, error, done, up_hold, busy, mem_we);
    end
    @(negedge clock);
    n_cmp++;
    if ((wr_cnt - w0) != 0 || (err_cnt - e0) != 1 || error !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_header_after(len=%0d): writes=%0d errs=%0d err_now=%b want 0 1 0",
               at_len, wr_cnt - w0, err_cnt - e0, error);
    end
  endtask

  task automatic test_noise_gaps();
    logic [7:0] noise[$];
    logic [7:0] q[$];
    noise = '{8'h00, 8'hFF, 8'h12};
    foreach (noise[i]) begin
      put(noise[i]);
      n_cmp++;
      if ({busy, up_hold, mem_we, done, error} !== 5'b00000) begin
        n_bad++;
        $display("FAIL noise[%0d]=%h: busy=%b hold=%b we=%b done=%b err=%b want 00000",
                 i, noise[i], busy, up_hold, mem_we, done, error);
      end
      gap(0, 2);
    end
    q = '{8'h0F, 8'h16, 8'hE0};
    run_frame(12'h000, q, -1, 1, 5, "frame_gaps");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] q[$];
    int w0, d0, e0;
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    put(8'hA5); put(8'h01); put(8'h20); put(8'h00); put(8'h04);
    put(8'h11); put(8'h22);
    in_data = 8'h33; in_valid = 1'b1; reset = 1'b1;
    @(negedge clock);
    in_valid = 1'b0; reset = 1'b0;
    n_cmp++;
    if ({mem_we, up_hold, busy, done, error, mem_addr} !== {5'b00000, 12'h000}) begin
      n_bad++;
      $display("FAIL reset_mid: we=%b hold=%b busy=%b done=%b err=%b addr=%h want all 0",
               mem_we, up_hold, busy, done, error, mem_addr);
    end
    repeat (3) @(negedge clock);
    n_cmp++;
    if ((wr_cnt - w0) != 2 || (done_cnt - d0) != 0 || (err_cnt - e0) != 0) begin
      n_bad++;
      $display("FAIL reset_mid_counts: writes=%0d done=%0d err=%0d want 2 0 0",
               wr_cnt - w0, done_cnt - d0, err_cnt - e0);
    end
    q = '{8'hA5, 8'h5A, 8'h00, 8'h7E};
    run_frame(12'h120, q, -1, 0, 1, "frame_after_reset");
  endtask

  task automatic test_random();
    logic [7:0]  q[$];
    logic [11:0] a;
    int          len;
    for (int f = 0; f < 16; f++) begin
      q.delete();
      len = 1 + int'($urandom_range(7, 0));
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      a = (f % 4 == 0) ? 12'hFFD : 12'($urandom);
      run_frame(a, q, ($urandom_range(2, 0) == 0) ? int'($urandom_range(255, 0)) : -1,
                0, 2, "frame_rand");
    end
    q.delete();
    for (int i = 0; i < 300; i++) q.push_back(8'($urandom));
    run_frame(12'hF80, q, -1, 0, 0, "frame_long");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_bad_header(1'b0);
    test_bad_header(1'b1);
    test_noise_gaps();
    test_reset_mid_frame();
    test_random();
    n_cmp++;
    if (both_cnt != 0 || nrdy_cnt != 0) begin
      n_bad++;
      $display("FAIL global: done_and_error_cycles=%0d not_ready_cycles=%0d want 0 0", both_cnt, nrdy_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
